// File: rtl/fifo_rd_stream_pkg.sv
// Shared definitions for the FIFO read-side stream block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_rd_stream_pkg;

    // Skid buffer occupancy; the encoding doubles as the OCC status value.
    typedef enum logic [1:0] {
        O0 = 2'd0,
        O1 = 2'd1,
        O2 = 2'd2
    } occ_e;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BURST_LEN  = 4;
    localparam int DEF_CNT_WIDTH  = 3;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus downstream valid/ready stream, bundled as one interface.
// Latency: n/a (wiring only).
// Backpressure: M_READY from the sink; EMPTY from the FIFO gates R_INC.
// Ports: EMPTY/RD_DATA/R_INC (FIFO read side), EN (drain enable),
//        M_DATA/M_VALID/M_READY/M_LAST (stream), OCC (buffer occupancy).
interface fifo_rd_stream_if
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  R_INC;
    logic                  EN;
    logic [DATA_WIDTH-1:0] M_DATA;
    logic                  M_VALID;
    logic                  M_READY;
    logic                  M_LAST;
    logic [1:0]            OCC;

    // master: the reader block (pops the FIFO, sources the stream)
    modport master (
        input  EMPTY, RD_DATA, EN, M_READY,
        output R_INC, M_DATA, M_VALID, M_LAST, OCC
    );

    // slave: the surrounding FIFO / sink
    modport slave (
        output EMPTY, RD_DATA, EN, M_READY,
        input  R_INC, M_DATA, M_VALID, M_LAST, OCC
    );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// Two-entry register buffer (main + skid) with occupancy FSM and valid/ready output.
// Latency: word pushed at edge k is presented on m_dat_o in cycle k+1 when empty.
// Backpressure: absorbs one extra word while m_rdy_i is low; caller must not push in O2.
// Ports: clk/rst_n, push_i/push_dat_i (write side), m_vld_o/m_dat_o/m_rdy_i (stream), occ_o.
module fifo_rd_stream_skid_buf
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    output logic                  m_vld_o,
    output logic [DATA_WIDTH-1:0] m_dat_o,
    input  logic                  m_rdy_i,
    output occ_e                  occ_o
);
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    occ_e                  occ_q;
    logic                  acc;

    assign acc = (occ_q != O0) & m_rdy_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
            occ_q  <= O0;
        end else begin
            case (occ_q)
                O0: begin
                    if (push_i) begin
                        main_q <= push_dat_i;
                        occ_q  <= O1;
                    end
                end
                O1: begin
                    if (push_i && acc) begin
                        main_q <= push_dat_i;
                    end else if (push_i) begin
                        // Sink stalled: park the new word behind the head.
                        skid_q <= push_dat_i;
                        occ_q  <= O2;
                    end else if (acc) begin
                        occ_q  <= O0;
                    end
                end
                O2: begin
                    // Full: the head leaves and the skid word moves up on the same edge.
                    if (acc) begin
                        main_q <= skid_q;
                        occ_q  <= O1;
                    end
                end
                default: occ_q <= O0;
            endcase
        end
    end

    assign m_vld_o = (occ_q != O0);
    assign m_dat_o = main_q;
    assign occ_o   = occ_q;
endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream, marking bursts with M_LAST.
// Latency: word popped at edge k is on M_DATA with M_VALID=1 in cycle k+1 (empty buffer).
// Backpressure: R_INC depends only on registered occupancy, never on M_READY; stops at OCC=2.
// Ports: CLK, RST (async active-low), bus (FIFO read side + stream, master modport).
module fifo_rd_stream
    import fifo_rd_stream_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic              CLK,
    input  logic              RST,
    fifo_rd_stream_if.master  bus
);
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

    occ_e                  occ;
    logic                  r_inc;
    logic                  m_vld;
    logic [DATA_WIDTH-1:0] m_dat;
    logic                  acc;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [CNT_WIDTH-1:0]  cnt_d;

    // RST term keeps the pop strobe low throughout reset even though EMPTY may be 0.
    assign r_inc = RST & ~bus.EMPTY & bus.EN & (occ != O2);

    fifo_rd_stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid_buf (
        .clk        (CLK),
        .rst_n      (RST),
        .push_i     (r_inc),
        .push_dat_i (bus.RD_DATA),
        .m_vld_o    (m_vld),
        .m_dat_o    (m_dat),
        .m_rdy_i    (bus.M_READY),
        .occ_o      (occ)
    );

    assign acc = m_vld & bus.M_READY;

    // Beat position only moves on accepts, so EN gaps leave the burst position intact.
    always_comb begin
        cnt_d = cnt_q;
        if (acc) begin
            cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.R_INC   = r_inc;
    assign bus.M_DATA  = m_dat;
    assign bus.M_VALID = m_vld;
    assign bus.M_LAST  = m_vld & (cnt_q == LAST_CNT);
    assign bus.OCC     = occ;
endmodule
